// File: rtl/div393_ctrl.sv
// Sequencer for a dual 4-bit ripple counter used as an 8-bit divide-by-N.
// Optional q_fb cross-check and sticky err output when DIV393_CHECK_EN is defined.
module div393_ctrl #(
  parameter bit ONESHOT_DEF = 1'b0
) (
  input  logic       clk,
  input  logic       clr1,
  input  logic       ce,
  input  logic       start,
  input  logic       stop,
  input  logic       oneshot,
  input  logic [7:0] div_val,
  input  logic [7:0] q_fb,
  output logic       cnt_clk1,
  output logic       cnt_clk2,
  output logic       cnt_clr,
  output logic       ack,
  output logic       busy,
  output logic       tick,
  output logic [7:0] shadow
`ifdef DIV393_CHECK_EN
  ,
  output logic       err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_HI, S_LO} state_t;

  state_t     state_q, state_d;
  logic [8:0] term_q, term_d;
  logic       mode_q, mode_d;
  logic [7:0] shadow_q, shadow_d;
  logic       stop_pend_q, stop_pend_d;
  logic       ack_q, ack_d;
  logic       tick_q, tick_d;
  logic       cnt_clk1_q, cnt_clk1_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       busy_q, busy_d;
  logic [7:0] shadow_inc;
  logic       hit;
  logic       accept;

  assign shadow_inc = shadow_q + 8'd1;
  // Terminal count is taken mod 256 so that N=256 fires when the count wraps to 0.
  assign hit        = (shadow_inc == term_q[7:0]);
  assign accept     = (state_q == S_IDLE) && start && !stop;

  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    mode_d      = mode_q;
    shadow_d    = shadow_q;
    stop_pend_d = stop_pend_q;
    ack_d       = 1'b0;
    tick_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (accept) begin
          term_d  = (div_val == 8'd0) ? 9'd256 : {1'b0, div_val};
          mode_d  = oneshot;
          ack_d   = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        shadow_d = 8'd0;
        state_d  = stop ? S_IDLE : S_HI;
      end
      S_HI: begin
        // A stop seen while clk1 is high still lets the falling edge happen.
        stop_pend_d = stop;
        state_d     = S_LO;
      end
      S_LO: begin
        shadow_d    = shadow_inc;
        stop_pend_d = 1'b0;
        tick_d      = hit;
        if (stop || stop_pend_q) state_d = S_IDLE;
        else if (hit)            state_d = mode_q ? S_IDLE : S_CLR;
        else                     state_d = S_HI;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_clk1_d = (state_d == S_HI);
    cnt_clr_d  = (state_d == S_IDLE) || (state_d == S_CLR);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge clr1) begin
    if (clr1) begin
      state_q     <= S_IDLE;
      term_q      <= 9'd0;
      mode_q      <= ONESHOT_DEF;
      shadow_q    <= 8'd0;
      stop_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
      cnt_clk1_q  <= 1'b0;
      cnt_clr_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      term_q      <= term_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      stop_pend_q <= stop_pend_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
      cnt_clk1_q  <= cnt_clk1_d;
      cnt_clr_q   <= cnt_clr_d;
      busy_q      <= busy_d;
    end
  end

  assign cnt_clk1 = cnt_clk1_q;
  assign cnt_clk2 = shadow_q[3];
  assign cnt_clr  = cnt_clr_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign tick     = tick_q;
  assign shadow   = shadow_q;

`ifdef DIV393_CHECK_EN
  logic       chk_pend_q, chk_pend_d;
  logic       err_q, err_d;
  logic [7:0] q_exp;
  logic       unused_term;

  assign unused_term = term_q[8];
  // The counter is held clear in CLR/IDLE, so only HI compares against shadow.
  assign q_exp       = (state_q == S_HI) ? shadow_q : 8'd0;

  always_comb begin
    chk_pend_d = (state_q == S_LO);
    err_d      = err_q;
    if (chk_pend_q && (q_fb != q_exp)) err_d = 1'b1;
    if (accept)                        err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clr1) begin
    if (clr1) begin
      chk_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (ce) begin
      chk_pend_q <= chk_pend_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_fb;
  assign unused_fb = ^{q_fb, term_q[8]};
`endif

endmodule

// File: tb/tb_div393_ctrl.sv
// Scoreboard bench for div393_ctrl: expected ticks queued at start, checked when tick fires.
module tb_div393_ctrl;
  logic       clk = 1'b0;
  logic       clr1, ce, start, stop, oneshot;
  logic [7:0] div_val, q_fb;
  logic       cnt_clk1, cnt_clk2, cnt_clr, ack, busy, tick;
  logic [7:0] shadow;
`ifdef DIV393_CHECK_EN
  logic       err;
`endif

  div393_ctrl dut (
    .clk(clk), .clr1(clr1), .ce(ce), .start(start), .stop(stop),
    .oneshot(oneshot), .div_val(div_val), .q_fb(q_fb),
    .cnt_clk1(cnt_clk1), .cnt_clk2(cnt_clk2), .cnt_clr(cnt_clr),
    .ack(ack), .busy(busy), .tick(tick), .shadow(shadow)
`ifdef DIV393_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // external counter model: counts on falling clk1, async clear
  logic [7:0] cnt_model = 8'd0;
  bit         stuck = 1'b0;
  always @(negedge cnt_clk1 or posedge cnt_clr)
    if (cnt_clr) cnt_model <= 8'd0;
    else         cnt_model <= cnt_model + 8'd1;
  assign q_fb = stuck ? 8'd0 : cnt_model;

  // ce generator: continuous, or every third clk
  bit ce_mode = 1'b0;
  int ph = 0;
  always @(negedge clk) begin
    ph <= (ph + 1) % 3;
    ce <= ce_mode ? (ph == 2) : 1'b1;
  end
  initial ce = 1'b1;

  int cyc = 0;
  int clkn = 0;
  bit ce_at_pos = 1'b0;
  always @(posedge clk) begin
    clkn      <= clkn + 1;
    ce_at_pos <= ce;
    if (ce && !clr1) cyc <= cyc + 1;
  end

  typedef struct { int cyc; int sh; } exp_t;
  exp_t sb[$];

  int          last_tick_clk = 0, prev_tick_clk = 0;
  logic [13:0] snap;
  bit          have_snap = 1'b0;

  always @(negedge clk) begin
    if (!clr1 && ce_at_pos && tick === 1'b1) begin
      if (sb.size() == 0) chk("tick_unexp", tick, 0);
      else begin
        chk("tick_cyc", cyc, sb[0].cyc);
        chk("tick_shadow", shadow, sb[0].sh);
        void'(sb.pop_front());
        prev_tick_clk <= last_tick_clk;
        last_tick_clk <= clkn;
      end
    end
    if (!clr1 && !ce_at_pos && have_snap)
      chk("hold", {cnt_clk1, cnt_clk2, cnt_clr, ack, busy, tick, shadow}, snap);
    snap      <= {cnt_clk1, cnt_clk2, cnt_clr, ack, busy, tick, shadow};
    have_snap <= 1'b1;
  end

  task automatic next_ce();
    do @(posedge clk); while (!ce);
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit os, output int e0);
    div_val = n[7:0];
    oneshot = os;
    start   = 1'b1;
    stop    = 1'b0;
    next_ce();
    start = 1'b0;
    e0    = cyc;
    chk("ack", ack, 1);
    chk("busy_start", busy, 1);
  endtask

  task automatic push_ticks(input int e0, input int n, input int k);
    int nn;
    nn = (n == 0) ? 256 : n;
    for (int i = 1; i <= k; i++) sb.push_back('{e0 + i * (2 * nn + 1), nn % 256});
  endtask

  task automatic wait_empty(input int lim);
    for (int i = 0; i < lim && sb.size() != 0; i++) next_ce();
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic watch_seq(input int n);
    for (int j = 1; j <= 2 * n + 2; j++) begin
      next_ce();
      chk("seq_shadow", shadow, (j <= 2 * n + 1) ? (j - 1) / 2 : 0);
      chk("seq_clk1", cnt_clk1, (j <= 2 * n) ? (j % 2) : (j == 2 * n + 2));
      chk("seq_clr", cnt_clr, (j == 2 * n + 1));
      if (j == 1) chk("ack_once", ack, 0);
    end
  endtask

  task automatic stop_now();
    stop = 1'b1;
    next_ce();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_clr", cnt_clr, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  int e0;
  initial begin
    clr1 = 1'b1; start = 1'b1; stop = 1'b0; oneshot = 1'b0; div_val = 8'd3;
    // reset with start held high
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clr", cnt_clr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_tick", tick, 0);
    chk("rst_shadow", shadow, 0);
    chk("rst_clk1", cnt_clk1, 0);
    clr1 = 1'b0;

    // periodic N=3, plus ignored start/config while busy
    do_start(3, 1'b0, e0);
    push_ticks(e0, 3, 3);
    watch_seq(3);
    start = 1'b1; div_val = 8'd9; oneshot = 1'b1;
    repeat (4) next_ce();
    start = 1'b0;
    chk("busy_run", busy, 1);
    wait_empty(40);
    stop_now();

    // one-shot N=256
    do_start(0, 1'b1, e0);
    push_ticks(e0, 0, 1);
    wait_empty(600);
    chk("os_busy", busy, 0);
    chk("os_clr", cnt_clr, 1);
    next_ce();
    chk("os_tick_gone", tick, 0);

    // stop in HI at shadow=1, N=5
    do_start(5, 1'b0, e0);
    repeat (3) next_ce();
    chk("hi_clk1", cnt_clk1, 1);
    chk("hi_shadow", shadow, 1);
    stop = 1'b1;
    next_ce();
    stop = 1'b0;
    chk("lo_clk1", cnt_clk1, 0);
    chk("lo_busy", busy, 1);
    next_ce();
    chk("stop_shadow", shadow, 2);
    chk("stop_idle", busy, 0);
    chk("stop_clr", cnt_clr, 1);
    repeat (12) next_ce();

    // stop in HI where the completing LO is terminal, N=1
    do_start(1, 1'b0, e0);
    push_ticks(e0, 1, 1);
    next_ce();
    stop = 1'b1;
    next_ce();
    stop = 1'b0;
    next_ce();
    chk("term_stop_busy", busy, 0);
    wait_empty(2);
    repeat (6) next_ce();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    next_ce();
    chk("coll_ack", ack, 0);
    chk("coll_busy", busy, 0);
    start = 1'b0; stop = 1'b0;
    next_ce();
    chk("coll_ack2", ack, 0);

    // ce every third clk, N=2
    ce_mode = 1'b1;
    do_start(2, 1'b0, e0);
    push_ticks(e0, 2, 3);
    wait_empty(40);
    chk("ce_period", last_tick_clk - prev_tick_clk, 15);
    stop_now();
    ce_mode = 1'b0;
    repeat (2) next_ce();

`ifdef DIV393_CHECK_EN
    chk("err_clean", err, 0);
    stuck = 1'b1;
    do_start(4, 1'b0, e0);
    push_ticks(e0, 4, 1);
    repeat (4) next_ce();
    chk("err_set", err, 1);
    wait_empty(20);
    chk("err_sticky", err, 1);
    stop_now();
    stuck = 1'b0;
    do_start(4, 1'b0, e0);
    chk("err_cleared", err, 0);
    push_ticks(e0, 4, 1);
    wait_empty(20);
    chk("err_good_run", err, 0);
    stop_now();
`endif

    repeat (3) next_ce();
    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
